// File: rtl/clause_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clause_feeder : streams clauses from a table into a literal evaluator and
//                 tallies broken clauses for one variable assignment.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module clause_feeder #(
  parameter  int NSAT        = 3,
  parameter  int NUM_VARS    = 8,
  parameter  int NUM_CLAUSES = 4,
  localparam int VAR_W       = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
  localparam int CL_W        = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
  localparam int CNT_W       = $clog2(NUM_CLAUSES + 1),
  localparam int LIT_W       = VAR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [NUM_VARS-1:0]   assign_i,
  output logic                  cl_rd_o,
  output logic [CL_W-1:0]       cl_addr_o,
  input  logic [NSAT*LIT_W-1:0] cl_data_i,
  output logic [NSAT-1:0]       var_val_o,
  output logic [NSAT-1:0]       var_neg_o,
  output logic                  lit_valid_o,
  input  logic                  break_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      unsat_cnt_o,
  output logic [CL_W-1:0]       first_unsat_o,
  output logic                  first_unsat_vld_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CL_W-1:0] LAST_CL = CL_W'(NUM_CLAUSES - 1);

  logic [1:0]          state_q, state_d;
  logic [CL_W-1:0]     addr_q, addr_d;
  logic [NUM_VARS-1:0] snap_q;
  logic                dvld_q, lvld_q, bvld_q;
  logic [CL_W-1:0]     idx1_q, idx2_q, idx3_q;
  logic [NSAT-1:0]     val_q, val_d, neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CL_W-1:0]     first_q;
  logic                fvld_q;
  logic                start_acc;
  logic [LIT_W-1:0]    lit;

  assign start_acc = (state_q == S_IDLE) && start_i;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (addr_q == LAST_CL) state_d = S_DRAIN;
        else                   addr_d  = addr_q + CL_W'(1);
      end
      S_DRAIN: if (bvld_q && (idx3_q == LAST_CL)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cl_rd_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_RUN:   begin cl_rd_o = 1'b1; busy_o = 1'b1; end
      S_DRAIN: busy_o = 1'b1;
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  // Literal lookup; out-of-range variable indices read as false
  always_comb begin
    val_d = '0;
    neg_d = '0;
    lit   = '0;
    if (dvld_q) begin
      for (int j = 0; j < NSAT; j++) begin
        lit      = cl_data_i[j*LIT_W +: LIT_W];
        neg_d[j] = lit[VAR_W];
        if ({{(32-VAR_W){1'b0}}, lit[VAR_W-1:0]} < 32'(NUM_VARS)) begin
          val_d[j] = snap_q[lit[VAR_W-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      snap_q  <= '0;
      dvld_q  <= 1'b0;
      lvld_q  <= 1'b0;
      bvld_q  <= 1'b0;
      idx1_q  <= '0;
      idx2_q  <= '0;
      idx3_q  <= '0;
      val_q   <= '0;
      neg_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      fvld_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dvld_q <= cl_rd_o;
      idx1_q <= addr_q;
      lvld_q <= dvld_q;
      idx2_q <= idx1_q;
      val_q  <= val_d;
      neg_q  <= neg_d;
      bvld_q <= lvld_q;
      idx3_q <= idx2_q;
      if (start_acc) begin
        snap_q  <= assign_i;
        cnt_q   <= '0;
        first_q <= '0;
        fvld_q  <= 1'b0;
      end else if (bvld_q && break_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!fvld_q) begin
          first_q <= idx3_q;
          fvld_q  <= 1'b1;
        end
      end
    end
  end

  assign cl_addr_o         = addr_q;
  assign var_val_o         = val_q;
  assign var_neg_o         = neg_q;
  assign lit_valid_o       = lvld_q;
  assign unsat_cnt_o       = cnt_q;
  assign first_unsat_o     = first_q;
  assign first_unsat_vld_o = fvld_q;

endmodule
`default_nettype wire

// File: doc/clause_feeder.md
CLAUSE_FEEDER -- requirements
Module: clause_feeder

Interface
REQ-001 SHALL have parameter NSAT, default 3: literals per clause, matching the clause evaluator width.
REQ-002 SHALL have parameter NUM_VARS, default 8: number of variables; VAR_W = clog2(NUM_VARS).
REQ-003 SHALL have parameter NUM_CLAUSES, default 4: clause table depth; CL_W = clog2(NUM_CLAUSES), CNT_W = clog2(NUM_CLAUSES+1).
REQ-004 SHALL have port clk_i, input, 1: single clock, all state on the rising edge.
REQ-005 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1: request one evaluation pass.
REQ-007 SHALL have port assign_i, input, NUM_VARS: variable assignment, bit v = value of variable v.
REQ-008 SHALL have port cl_rd_o, output, 1: clause table read strobe.
REQ-009 SHALL have port cl_addr_o, output, CL_W: clause index being read.
REQ-010 SHALL have port cl_data_i, input, NSAT*(VAR_W+1): clause word, valid 1 cycle after cl_rd_o; literal j = bits [j*(VAR_W+1) +: VAR_W+1] = {neg, var_idx}.
REQ-011 SHALL have port var_val_o, output, NSAT: literal variable values to the evaluator.
REQ-012 SHALL have port var_neg_o, output, NSAT: literal negation flags to the evaluator (1 = negated literal).
REQ-013 SHALL have port lit_valid_o, output, 1: var_val_o/var_neg_o hold a clause this cycle.
REQ-014 SHALL have port break_i, input, 1: evaluator result, valid exactly 1 cycle after lit_valid_o.
REQ-015 SHALL have port busy_o, output, 1: pass in progress.
REQ-016 SHALL have port done_o, output, 1: single-cycle end-of-pass pulse.
REQ-017 SHALL have port unsat_cnt_o, output, CNT_W: number of broken clauses in the last pass.
REQ-018 SHALL have port first_unsat_o, output, CL_W: lowest broken clause index.
REQ-019 SHALL have port first_unsat_vld_o, output, 1: first_unsat_o is meaningful.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start_i, RUN->DRAIN after the last address, DRAIN->DONE after the last break_i sample, DONE->IDLE unconditionally.
REQ-021 SHALL, on accepting start_i in IDLE (cycle 0), snapshot assign_i into an internal register and clear unsat_cnt_o, first_unsat_o and first_unsat_vld_o.
REQ-022 SHALL use only the snapshot for lookups; assign_i changes during busy_o have no effect.
REQ-023 SHALL assert cl_rd_o with cl_addr_o = k in cycle k+1, for k = 0..NUM_CLAUSES-1, one clause per cycle, no bubbles.
REQ-024 SHALL register per literal j: var_val_o[j] = snapshot[var_idx_j] and var_neg_o[j] = neg_j, with lit_valid_o high in cycle k+3 for clause k.
REQ-025 SHALL drive var_val_o[j] = 0 when var_idx_j >= NUM_VARS.
REQ-026 SHALL sample break_i in cycle k+4 for clause k and increment unsat_cnt_o when it is 1; the counter cannot overflow, since its maximum is NUM_CLAUSES.
REQ-027 SHALL, on the first break_i = 1 of a pass, load first_unsat_o = k and set first_unsat_vld_o; later breaks SHALL NOT update it.
REQ-028 SHALL assert busy_o from cycle 1 through cycle NUM_CLAUSES+3, and pulse done_o in cycle NUM_CLAUSES+4 (DONE state).
REQ-029 SHALL ignore start_i while busy_o or done_o is high; no queuing.
REQ-030 SHALL hold result outputs stable from done_o until the next accepted start_i.
REQ-031 SHALL hold var_val_o/var_neg_o at 0 whenever lit_valid_o is 0.
REQ-032 SHALL ignore break_i outside the sampling cycles of REQ-026.

Reset
REQ-033 SHALL, while reset_i is high, immediately force FSM = IDLE and all outputs and the snapshot to 0, independent of clk_i.
REQ-034 SHALL, on reset mid-pass, abort the pass with no done_o pulse and discard partial results; a start_i on the first clock after reset deassertion SHALL be accepted.

Verification
REQ-035 SHALL cover: assert reset_i between clock edges -> all outputs 0 before the next edge.
REQ-036 SHALL cover: NSAT=3, NUM_VARS=8, NUM_CLAUSES=4, all positive literals, assign_i=8'hFF, start -> done_o in cycle 8, unsat_cnt_o=0, first_unsat_vld_o=0.
REQ-037 SHALL cover: same clauses, assign_i=8'h00 -> unsat_cnt_o=4, first_unsat_o=0, first_unsat_vld_o=1.
REQ-038 SHALL cover: only clause 2 = {x1,x2,x3} false under assign_i=8'hF1 (others satisfied) -> unsat_cnt_o=1, first_unsat_o=2.
REQ-039 SHALL cover: start_i re-asserted and assign_i toggled during busy_o -> results identical to an undisturbed pass, exactly one done_o.
REQ-040 SHALL cover: reset_i pulsed in cycle 3 of a pass -> no done_o, outputs 0, and a following start -> correct full pass.
